// File: rtl/reg_cut.sv
// reg_cut: register-bus timing cut between the bus multiplexer and a
// peripheral register file. Every output is driven from flops. The cut runs
// one transaction at a time, and each access costs at least 3 cycles.
//
// Handshake, upstream and downstream sides: the requester raises valid and
// holds valid and the payload stable until it sees ready high. The requester
// samples ready, rdata and error in the same cycle.
//
// Optional feature: define REG_CUT_TIMEOUT_EN to bound the downstream wait.
// After TimeoutCycles ISSUE cycles without ready, the cut answers upstream
// with error=1 and rdata=0. When the macro is not defined, ISSUE waits
// indefinitely.

package reg_cut_pkg;
  localparam int unsigned RegAw = 32;
  localparam int unsigned RegDw = 32;

  typedef struct packed {
    logic [RegAw-1:0]   addr;
    logic               write;
    logic [RegDw-1:0]   wdata;
    logic [RegDw/8-1:0] wstrb;
    logic               valid;
  } req_t;

  typedef struct packed {
    logic [RegDw-1:0] rdata;
    logic             error;
    logic             ready;
  } rsp_t;
endpackage

module reg_cut #(
  parameter int unsigned AW            = 32,
  parameter int unsigned DW            = 32,
  parameter type         req_t         = reg_cut_pkg::req_t,
  parameter type         rsp_t         = reg_cut_pkg::rsp_t,
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  req_t in_req_i,
  output rsp_t in_rsp_o,
  output req_t out_req_o,
  input  rsp_t out_rsp_i
);

  // Elaboration guard: a zero wait limit would make the timeout meaningless.
  if (TimeoutCycles < 1) begin : g_bad_timeout
    $error("reg_cut: TimeoutCycles must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Captured request payload. It holds its value through IDLE and RESP.
  logic [AW-1:0]   addr_q, addr_d;
  logic            write_q, write_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW/8-1:0] wstrb_q, wstrb_d;

  // Captured downstream response. It is shown upstream only in RESP.
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            error_q, error_d;

`ifdef REG_CUT_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
`endif

  // Next-state logic: capture in IDLE, wait in ISSUE, pulse ready in RESP.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    error_d = error_q;
`ifdef REG_CUT_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_req_i.valid) begin
          addr_d  = in_req_i.addr;
          write_d = in_req_i.write;
          wdata_d = in_req_i.wdata;
          wstrb_d = in_req_i.wstrb;
          state_d = ISSUE;
`ifdef REG_CUT_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ISSUE: begin
        // A real response takes priority over a timeout in the same cycle.
        if (out_rsp_i.ready) begin
          rdata_d = out_rsp_i.rdata;
          error_d = out_rsp_i.error;
          state_d = RESP;
        end
`ifdef REG_CUT_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntW'(TimeoutCycles - 1)) begin
            rdata_d = '0;
            error_d = 1'b1;
            state_d = RESP;
          end
        end
`endif
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, payload and response registers with asynchronous clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

`ifdef REG_CUT_TIMEOUT_EN
  // Counts downstream wait cycles. It is cleared when a request is captured.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  // Downstream request. The payload comes from registers and valid is set
  // only while in ISSUE.
  always_comb begin
    out_req_o       = '0;
    out_req_o.addr  = addr_q;
    out_req_o.write = write_q;
    out_req_o.wdata = wdata_q;
    out_req_o.wstrb = wstrb_q;
    out_req_o.valid = (state_q == ISSUE);
  end

  // Upstream response. It is zero everywhere except the single RESP cycle.
  always_comb begin
    in_rsp_o = '0;
    if (state_q == RESP) begin
      in_rsp_o.ready = 1'b1;
      in_rsp_o.rdata = rdata_q;
      in_rsp_o.error = error_q;
    end
  end

endmodule

// File: tb/tb_reg_cut.sv
// Directed bench for reg_cut. Each step advances one clock edge and then
// waits 1 ns. Outputs are checked at that point, and the inputs for the next
// edge are driven at the same point.
module tb_reg_cut;
  import reg_cut_pkg::*;

  logic clk;
  logic rst_n;
  req_t in_req;
  rsp_t in_rsp;
  req_t out_req;
  rsp_t out_rsp;

  int checks   = 0;
  int failures = 0;

  reg_cut #(.TimeoutCycles(8)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .in_req_i (in_req),
    .in_rsp_o (in_rsp),
    .out_req_o(out_req),
    .out_rsp_i(out_rsp)
  );

  // Clock and initial reset values.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_req  = '0;
    out_rsp = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    step();
    step();
    checks++;
    if (out_req !== '0) begin
      failures++;
      $display("FAIL reset_out_req: got %h want 0", out_req);
    end
    checks++;
    if (in_rsp !== '0) begin
      failures++;
      $display("FAIL reset_in_rsp: got %h want 0", in_rsp);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_read();
    in_req       = '0;
    in_req.addr  = 32'h10;
    in_req.valid = 1'b1;
    checks++;
    if (out_req.valid !== 1'b0) begin
      failures++;
      $display("FAIL read_valid_c0: got %b want 0", out_req.valid);
    end
    step();
    checks++;
    if (out_req.valid !== 1'b1 || out_req.addr !== 32'h10 || out_req.write !== 1'b0) begin
      failures++;
      $display("FAIL read_issue_c1: got v=%b a=%h w=%b want v=1 a=10 w=0",
               out_req.valid, out_req.addr, out_req.write);
    end
    checks++;
    if (in_rsp.ready !== 1'b0) begin
      failures++;
      $display("FAIL read_ready_c1: got %b want 0", in_rsp.ready);
    end
    out_rsp.ready = 1'b1;
    out_rsp.rdata = 32'hDEADBEEF;
    out_rsp.error = 1'b0;
    step();
    checks++;
    if (in_rsp.ready !== 1'b1 || in_rsp.rdata !== 32'hDEADBEEF || in_rsp.error !== 1'b0) begin
      failures++;
      $display("FAIL read_resp_c2: got r=%b d=%h e=%b want r=1 d=deadbeef e=0",
               in_rsp.ready, in_rsp.rdata, in_rsp.error);
    end
    checks++;
    if (out_req.valid !== 1'b0) begin
      failures++;
      $display("FAIL read_valid_c2: got %b want 0", out_req.valid);
    end
    idle_inputs();
    step();
    checks++;
    if (in_rsp.ready !== 1'b0 || in_rsp.rdata !== 32'h0) begin
      failures++;
      $display("FAIL read_idle_c3: got r=%b d=%h want r=0 d=0", in_rsp.ready, in_rsp.rdata);
    end
  endtask

  task automatic test_write_wait();
    in_req       = '0;
    in_req.addr  = 32'h24;
    in_req.write = 1'b1;
    in_req.wdata = 32'h0000A5A5;
    in_req.wstrb = 4'h3;
    in_req.valid = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_req.valid !== 1'b1 || out_req.addr !== 32'h24 || out_req.write !== 1'b1 ||
          out_req.wdata !== 32'h0000A5A5 || out_req.wstrb !== 4'h3) begin
        failures++;
        $display("FAIL write_issue_%0d: got v=%b a=%h w=%b d=%h s=%h want v=1 a=24 w=1 d=0000a5a5 s=3",
                 i, out_req.valid, out_req.addr, out_req.write, out_req.wdata, out_req.wstrb);
      end
      checks++;
      if (in_rsp.ready !== 1'b0) begin
        failures++;
        $display("FAIL write_early_ready_%0d: got %b want 0", i, in_rsp.ready);
      end
      if (i == 3) begin
        out_rsp.ready = 1'b1;
        out_rsp.rdata = 32'h00000055;
      end
      step();
    end
    checks++;
    if (in_rsp.ready !== 1'b1 || in_rsp.rdata !== 32'h55 || in_rsp.error !== 1'b0) begin
      failures++;
      $display("FAIL write_resp: got r=%b d=%h e=%b want r=1 d=55 e=0",
               in_rsp.ready, in_rsp.rdata, in_rsp.error);
    end
    idle_inputs();
    step();
    checks++;
    if (in_rsp.ready !== 1'b0) begin
      failures++;
      $display("FAIL write_ready_once: got %b want 0", in_rsp.ready);
    end
  endtask

  task automatic test_error();
    in_req       = '0;
    in_req.addr  = 32'h30;
    in_req.valid = 1'b1;
    step();
    out_rsp.ready = 1'b1;
    out_rsp.error = 1'b1;
    out_rsp.rdata = 32'h1234;
    step();
    checks++;
    if (in_rsp.ready !== 1'b1 || in_rsp.error !== 1'b1 || in_rsp.rdata !== 32'h1234) begin
      failures++;
      $display("FAIL error_resp: got r=%b e=%b d=%h want r=1 e=1 d=1234",
               in_rsp.ready, in_rsp.error, in_rsp.rdata);
    end
    idle_inputs();
    step();
    checks++;
    if (in_rsp.error !== 1'b0) begin
      failures++;
      $display("FAIL error_clear: got %b want 0", in_rsp.error);
    end
  endtask

  task automatic test_back_to_back();
    in_req       = '0;
    in_req.addr  = 32'h40;
    in_req.valid = 1'b1;
    step();
    out_rsp.ready = 1'b1;
    out_rsp.rdata = 32'h11111111;
    step();
    checks++;
    if (in_rsp.ready !== 1'b1 || in_rsp.rdata !== 32'h11111111) begin
      failures++;
      $display("FAIL b2b_first: got r=%b d=%h want r=1 d=11111111", in_rsp.ready, in_rsp.rdata);
    end
    // valid stays high and the address changes while the cut is in RESP.
    in_req.addr = 32'h44;
    out_rsp     = '0;
    step();
    checks++;
    if (out_req.valid !== 1'b0 || in_rsp.ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle: got v=%b r=%b want v=0 r=0", out_req.valid, in_rsp.ready);
    end
    step();
    checks++;
    if (out_req.valid !== 1'b1 || out_req.addr !== 32'h44) begin
      failures++;
      $display("FAIL b2b_issue: got v=%b a=%h want v=1 a=44", out_req.valid, out_req.addr);
    end
    out_rsp.ready = 1'b1;
    out_rsp.rdata = 32'h22222222;
    step();
    checks++;
    if (in_rsp.ready !== 1'b1 || in_rsp.rdata !== 32'h22222222) begin
      failures++;
      $display("FAIL b2b_second: got r=%b d=%h want r=1 d=22222222", in_rsp.ready, in_rsp.rdata);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid();
    in_req       = '0;
    in_req.addr  = 32'h50;
    in_req.valid = 1'b1;
    step();
    checks++;
    if (out_req.valid !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_issue: got %b want 1", out_req.valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_req !== '0 || in_rsp !== '0) begin
      failures++;
      $display("FAIL rstmid_async: got req=%h rsp=%h want 0", out_req, in_rsp);
    end
    idle_inputs();
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (out_req !== '0) begin
      failures++;
      $display("FAIL rstmid_after: got %h want 0", out_req);
    end
    in_req.addr  = 32'h60;
    in_req.valid = 1'b1;
    step();
    checks++;
    if (out_req.valid !== 1'b1 || out_req.addr !== 32'h60) begin
      failures++;
      $display("FAIL rstmid_new_issue: got v=%b a=%h want v=1 a=60", out_req.valid, out_req.addr);
    end
    out_rsp.ready = 1'b1;
    out_rsp.rdata = 32'hCAFEF00D;
    step();
    checks++;
    if (in_rsp.ready !== 1'b1 || in_rsp.rdata !== 32'hCAFEF00D) begin
      failures++;
      $display("FAIL rstmid_new_resp: got r=%b d=%h want r=1 d=cafef00d", in_rsp.ready, in_rsp.rdata);
    end
    idle_inputs();
    step();
  endtask

`ifdef REG_CUT_TIMEOUT_EN
  task automatic test_timeout();
    in_req       = '0;
    in_req.addr  = 32'h70;
    in_req.valid = 1'b1;
    step();
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (out_req.valid !== 1'b1 || in_rsp.ready !== 1'b0) begin
        failures++;
        $display("FAIL timeout_wait_%0d: got v=%b r=%b want v=1 r=0", i, out_req.valid, in_rsp.ready);
      end
      step();
    end
    checks++;
    if (in_rsp.ready !== 1'b1 || in_rsp.error !== 1'b1 || in_rsp.rdata !== 32'h0 ||
        out_req.valid !== 1'b0) begin
      failures++;
      $display("FAIL timeout_resp: got r=%b e=%b d=%h v=%b want r=1 e=1 d=0 v=0",
               in_rsp.ready, in_rsp.error, in_rsp.rdata, out_req.valid);
    end
    idle_inputs();
    step();
    // The real response arrives in the 8th ISSUE cycle and takes priority.
    in_req.addr  = 32'h74;
    in_req.valid = 1'b1;
    step();
    for (int i = 1; i < 8; i++) step();
    out_rsp.ready = 1'b1;
    out_rsp.rdata = 32'hBEEF0001;
    step();
    checks++;
    if (in_rsp.ready !== 1'b1 || in_rsp.error !== 1'b0 || in_rsp.rdata !== 32'hBEEF0001) begin
      failures++;
      $display("FAIL timeout_race: got r=%b e=%b d=%h want r=1 e=0 d=beef0001",
               in_rsp.ready, in_rsp.error, in_rsp.rdata);
    end
    idle_inputs();
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_read();
    test_write_wait();
    test_error();
    test_back_to_back();
    test_reset_mid();
`ifdef REG_CUT_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_cut.md
Name: reg_cut

Overview:
- Register-bus timing cut placed directly downstream of the register-bus multiplexer output and upstream of the peripheral register file.
- Breaks every combinational path between upstream and downstream: the request payload, valid, ready, rdata and error all come from flops.
- Handles one transaction at a time.
- Trades latency (minimum 3 cycles per access) for closing timing across long interconnect routes.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits; the strobe width is DW/8.
- req_t, logic, register-bus request struct with fields addr, write, wdata, wstrb, valid.
- rsp_t, logic, register-bus response struct with fields rdata, error, ready.
- TimeoutCycles, 256, downstream wait limit; used only when REG_CUT_TIMEOUT_EN is defined; must be at least 1.

Ports:
- clk_i  in  1  single clock; all state is on its rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- in_req_i  in  req_t  upstream request (from the mux).
- in_rsp_o  out  rsp_t  upstream response.
- out_req_o  out  req_t  downstream request.
- out_rsp_i  in  rsp_t  downstream response.

Behaviour:
- Protocol, both sides: the requester holds valid and the payload stable until ready is high; ready, rdata and error are sampled in the same cycle.
- The FSM has three states: IDLE, ISSUE, RESP. Reset state is IDLE.
- IDLE:
  - in_rsp_o.ready=0, out_req_o.valid=0.
  - If in_req_i.valid=1: capture addr, write, wdata, wstrb into payload registers, then go to ISSUE.
- ISSUE:
  - out_req_o.valid=1; out_req_o fields come from the payload registers.
  - If out_rsp_i.ready=1: capture rdata and error into the response registers, then go to RESP. Otherwise stay in ISSUE.
- RESP:
  - in_rsp_o.ready=1; in_rsp_o.rdata and error come from the response registers.
  - Go to IDLE unconditionally.
- in_rsp_o.rdata and error are 0 outside RESP.
- out_req_o payload fields hold their last captured value in IDLE and RESP.
- Latency, with downstream ready in the first ISSUE cycle:
  - Upstream valid at cycle 0, downstream valid at cycle 1, upstream ready at cycle 2.
  - The next request can be captured at cycle 3 at the earliest.
- Each cycle of downstream wait adds one cycle to the total.
- No combinational path exists from any input to any output.
- Upstream valid dropped during ISSUE (a protocol violation): the downstream transaction still completes and RESP still pulses ready for 1 cycle.
- Upstream valid still high in RESP: it is the same transaction and is not re-captured. Capture happens only in IDLE.
- Reset values: all out_req_o fields 0, all in_rsp_o fields 0, payload/response registers 0, state IDLE.
- Reset asserted mid-transaction: outputs go to 0 immediately (asynchronously) and the transaction is dropped. The next access after reset release starts fresh from IDLE.
- Write and read are handled identically. For writes, the downstream rdata is still captured and forwarded.

Optional Feature:
- Macro: REG_CUT_TIMEOUT_EN.
- Defined:
  - A wait counter of $clog2(TimeoutCycles+1) bits clears on entry to ISSUE and increments each ISSUE cycle without out_rsp_i.ready.
  - When the count reaches TimeoutCycles with ready still low, go to RESP with captured error=1 and rdata=0, and deassert out_req_o.valid.
  - If ready and the timeout occur in the same cycle, ready wins and the real response is forwarded.
  - The counter resets to 0.
- Not defined: no counter; ISSUE waits indefinitely.

Test Plan:
- Read, downstream ready in the first ISSUE cycle: addr=0x10, downstream rdata=0xDEADBEEF, error=0.
  - Required: out_req_o.valid high in cycle 1 only.
  - Required: in_rsp_o.ready high in cycle 2 only, with rdata=0xDEADBEEF and error=0.
- Write with wait states: addr=0x24, wdata=0x0000A5A5, wstrb=0x3; downstream ready after 4 cycles.
  - Required: out_req_o payload stable for all 4 ISSUE cycles.
  - Required: upstream ready exactly 1 cycle later.
- Downstream error: downstream returns error=1 and rdata=0x1234.
  - Required: in_rsp_o.error=1 and rdata=0x1234 on the upstream ready cycle.
- Back-to-back: upstream keeps valid high with a new addr immediately after its ready.
  - Required: second capture in the IDLE cycle following RESP; second upstream ready arrives 3 cycles after the first.
- Reset mid-ISSUE: assert rst_ni=0 while out_req_o.valid=1.
  - Required: all outputs 0 immediately.
  - Required: after release, a new read completes with 3-cycle latency.
- Timeout, REG_CUT_TIMEOUT_EN defined, TimeoutCycles=8, downstream never ready.
  - Required: upstream ready with error=1 and rdata=0 in the cycle after the 8th ISSUE cycle.
  - Required: ready asserted exactly in that 8th cycle instead returns the real response.
